// File: rtl/shared_mult_pkg.sv
// shared_mult_pkg: shared constants and helpers for the
// round-robin time-multiplexed multiplier.
package shared_mult_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_CHANNELS = 4;
  localparam int DEF_PIPE     = 2;
  localparam bit DEF_SIGNED   = 1'b0;

  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant with a rotating
// priority pointer that advances past each granted channel.
module rr_arbiter
  import shared_mult_pkg::*;
#(
  parameter int  CHANNELS = DEF_CHANNELS,
  localparam int CW       = ch_w(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] req,
  input  logic                en,
  output logic [CHANNELS-1:0] gnt,
  output logic [CW-1:0]       idx
);

  logic [CW-1:0] ptr_q;
  logic [CW-1:0] ptr_d;
  logic          hit;
  int            k;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    hit   = 1'b0;
    ptr_d = ptr_q;
    k     = 0;
    for (int j = 0; j < CHANNELS; j++) begin
      k = int'(ptr_q) + j;
      if (k >= CHANNELS) k = k - CHANNELS;
      if (en && !hit && req[k]) begin
        hit    = 1'b1;
        gnt[k] = 1'b1;
        idx    = CW'(k);
      end
    end
    if (hit) begin
      ptr_d = (int'(idx) == CHANNELS - 1) ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/shared_mult_rr.sv
// shared_mult_rr: one pipelined WIDTH x WIDTH multiplier shared
// by CHANNELS requesters through a round-robin arbiter.
module shared_mult_rr
  import shared_mult_pkg::*;
#(
  parameter int  WIDTH    = DEF_WIDTH,
  parameter int  CHANNELS = DEF_CHANNELS,
  parameter int  PIPE     = DEF_PIPE,
  parameter bit  SIGNED   = DEF_SIGNED,
  localparam int CW       = ch_w(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_a,
  input  logic [CHANNELS*WIDTH-1:0] in_b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*WIDTH-1:0]        out_prod,
  output logic [CW-1:0]             out_ch
);

  typedef struct packed {
    logic               valid;
    logic [CW-1:0]      ch;
    logic [2*WIDTH-1:0] prod;
  } stage_t;

  stage_t             pipe_q [PIPE];
  stage_t             s1_d;
  logic               stall;
  logic [CHANNELS-1:0] gnt;
  logic [CW-1:0]      gidx;
  logic [WIDTH-1:0]   a_sel;
  logic [WIDTH-1:0]   b_sel;
  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;

  // A full output register that the consumer refuses freezes everything.
  assign stall = pipe_q[PIPE-1].valid && !out_ready;

  rr_arbiter #(
    .CHANNELS(CHANNELS)
  ) u_arb (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (in_valid),
    .en   (!stall),
    .gnt  (gnt),
    .idx  (gidx)
  );

  assign in_ready = gnt;

  always_comb begin
    a_sel = in_a[int'(gidx)*WIDTH +: WIDTH];
    b_sel = in_b[int'(gidx)*WIDTH +: WIDTH];
    if (SIGNED) begin
      a_ext = {{WIDTH{a_sel[WIDTH-1]}}, a_sel};
      b_ext = {{WIDTH{b_sel[WIDTH-1]}}, b_sel};
    end else begin
      a_ext = {{WIDTH{1'b0}}, a_sel};
      b_ext = {{WIDTH{1'b0}}, b_sel};
    end
    s1_d.valid = |gnt;
    s1_d.ch    = gidx;
    s1_d.prod  = (|gnt) ? a_ext * b_ext : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE; i++) pipe_q[i] <= '0;
    end else if (!stall) begin
      pipe_q[0] <= s1_d;
      for (int i = 1; i < PIPE; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign out_valid = pipe_q[PIPE-1].valid;
  assign out_prod  = pipe_q[PIPE-1].prod;
  assign out_ch    = pipe_q[PIPE-1].ch;

endmodule

// File: tb/tb_shared_mult_rr.sv
// tb_shared_mult_rr: unsigned and signed instances on shared stimulus,
// checked against a slot-queue model of the shared multiplier.
module tb_shared_mult_rr;

  localparam int W  = 8;
  localparam int CH = 4;
  localparam int P  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] in_valid;
  logic [CH*W-1:0] in_a;
  logic [CH*W-1:0] in_b;
  logic          out_ready;
  logic [CH-1:0] rdy_u, rdy_s;
  logic          ov_u, ov_s;
  logic [2*W-1:0] prod_u, prod_s;
  logic [1:0]    ch_u, ch_s;

  always #5 clk = ~clk;

  shared_mult_rr #(.WIDTH(W), .CHANNELS(CH), .PIPE(P), .SIGNED(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_u),
    .in_a(in_a), .in_b(in_b), .out_valid(ov_u), .out_ready(out_ready),
    .out_prod(prod_u), .out_ch(ch_u)
  );

  shared_mult_rr #(.WIDTH(W), .CHANNELS(CH), .PIPE(P), .SIGNED(1'b1)) u_sdut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_s),
    .in_a(in_a), .in_b(in_b), .out_valid(ov_s), .out_ready(out_ready),
    .out_prod(prod_s), .out_ch(ch_s)
  );

  typedef struct {
    bit v;
    int ch;
    int a;
    int b;
  } slot_t;

  typedef struct {
    int ch;
    int a;
    int b;
    int eu;
    int es;
  } vec_t;

  slot_t slot [P];
  int    ptr;
  int    total = 0;
  int    bad = 0;
  int    accepted = 0;
  int    delivered = 0;

  function automatic logic [15:0] mul_u(input int a, input int b);
    int r;
    r = a * b;
    return r[15:0];
  endfunction

  function automatic logic [15:0] mul_s(input int a, input int b);
    int sa, sb, r;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    r  = sa * sb;
    return r[15:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < P; i++) slot[i] = '{0, 0, 0, 0};
    ptr = 0;
  endtask

  task automatic set_op(input int c, input int a, input int b);
    in_a[c*W +: W] = 8'(a);
    in_b[c*W +: W] = 8'(b);
  endtask

  task automatic rand_ops();
    in_a = $urandom;
    in_b = $urandom;
  endtask

  // One clock: check what the model predicts, then advance it at the edge.
  task automatic cycle();
    bit   stall;
    int   g;
    logic [CH-1:0] eg;
    #1;
    stall = slot[P-1].v && !out_ready;
    g = -1;
    if (!stall) begin
      for (int j = 0; j < CH; j++) begin
        int k;
        k = (ptr + j) % CH;
        if (g < 0 && in_valid[k]) g = k;
      end
    end
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    chk("in_ready_u", rdy_u, eg);
    chk("in_ready_s", rdy_s, eg);
    chk("out_valid_u", ov_u, slot[P-1].v);
    chk("out_valid_s", ov_s, slot[P-1].v);
    if (slot[P-1].v) begin
      chk("prod_u", prod_u, mul_u(slot[P-1].a, slot[P-1].b));
      chk("prod_s", prod_s, mul_s(slot[P-1].a, slot[P-1].b));
      chk("ch_u", ch_u, slot[P-1].ch);
      chk("ch_s", ch_s, slot[P-1].ch);
    end
    @(posedge clk);
    if (!stall) begin
      if (slot[P-1].v && out_ready) delivered++;
      for (int i = P - 1; i > 0; i--) slot[i] = slot[i-1];
      if (g >= 0) begin
        slot[0] = '{1, g, int'(in_a[g*W +: W]), int'(in_b[g*W +: W])};
        ptr = (g + 1) % CH;
        accepted++;
      end else begin
        slot[0] = '{0, 0, 0, 0};
      end
    end
    #1;
  endtask

  task automatic drain();
    in_valid  = '0;
    out_ready = 1'b1;
    repeat (P + 1) cycle();
  endtask

  vec_t vecs [7];
  logic [15:0] hp;
  logic [1:0]  hc;
  int          prev;

  initial begin
    vecs[0] = '{2, 255, 255, 65025, 16'h0001};
    vecs[1] = '{0, 128, 127, 16256, 16'hC080};
    vecs[2] = '{1, 0, 200, 0, 0};
    vecs[3] = '{3, 1, 255, 255, 16'hFFFF};
    vecs[4] = '{1, 127, 127, 16129, 16129};
    vecs[5] = '{3, 128, 128, 16384, 16'h4000};
    vecs[6] = '{0, 255, 1, 255, 16'hFFFF};

    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = 1'b1;
    in_a      = '0;
    in_b      = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", ov_u, 0);
    chk("rst_out_prod", prod_u, 0);
    chk("rst_out_ch", ch_u, 0);
    chk("rst_out_valid_s", ov_s, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // single requests with fixed expected products
    foreach (vecs[n]) begin
      in_valid = '0;
      in_valid[vecs[n].ch] = 1'b1;
      rand_ops();
      set_op(vecs[n].ch, vecs[n].a, vecs[n].b);
      #1;
      chk("vec_ready", rdy_u, 32'(in_valid));
      cycle();
      in_valid = '0;
      repeat (P - 1) cycle();
      #1;
      chk("vec_valid", ov_u, 1);
      chk("vec_prod_u", prod_u, vecs[n].eu);
      chk("vec_prod_s", prod_s, vecs[n].es);
      chk("vec_ch", ch_u, vecs[n].ch);
      cycle();
      cycle();
    end

    // round robin with all channels requesting
    drain();
    in_valid = '1;
    prev = ptr - 1;
    for (int c = 0; c < 10; c++) begin
      rand_ops();
      #1;
      chk("rr_order", rdy_u, 32'(1 << ((prev + 1) % CH)));
      prev = (prev + 1) % CH;
      cycle();
    end

    // back-pressure while full
    out_ready = 1'b0;
    #1;
    hp = prod_u;
    hc = ch_u;
    for (int c = 0; c < 3; c++) begin
      cycle();
      chk("bp_hold_prod", prod_u, hp);
      chk("bp_hold_ch", ch_u, hc);
      chk("bp_ready", rdy_u, 0);
    end
    out_ready = 1'b1;
    repeat (6) begin
      rand_ops();
      cycle();
    end
    drain();
    chk("bp_count", delivered, accepted);

    // asynchronous reset with results in flight
    accepted  = 0;
    delivered = 0;
    in_valid  = '1;
    rand_ops();
    cycle();
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid_u", ov_u, 0);
    chk("arst_valid_s", ov_s, 0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arst_first_gnt", rdy_u, 4'b0001);
    accepted  = 0;
    delivered = 0;
    cycle();
    drain();
    chk("arst_count", delivered, 1);

    // sparse traffic on channels 1 and 3
    accepted  = 0;
    delivered = 0;
    for (int c = 0; c < 40; c++) begin
      in_valid = (c % 4 == 0) ? 4'b0010 : (c % 4 == 2) ? 4'b1000 : 4'b0000;
      rand_ops();
      cycle();
    end
    drain();
    chk("sparse_accepted", accepted, 20);
    chk("sparse_delivered", delivered, accepted);

    // random traffic and back-pressure
    accepted  = 0;
    delivered = 0;
    for (int c = 0; c < 400; c++) begin
      in_valid  = 4'($urandom);
      out_ready = ($urandom % 4) != 0;
      rand_ops();
      cycle();
    end
    drain();
    chk("rand_count", delivered, accepted);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
